// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data memory: FSM encoding, default
// geometry and small sizing helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DEPTH      = 256;
    localparam int DEF_ND         = 3;

    function automatic int lanes_of(input int data_width);
        return data_width / 8;
    endfunction

    // Latency counter holds ND-1 down to 0; keep at least one bit for ND=1.
    function automatic int cnt_width(input int nd);
        return (nd > 1) ? $clog2(nd) : 1;
    endfunction

endpackage

// File: rtl/data_memory_multicycle_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
interface data_memory_multicycle_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    MemRead;
    logic                    MemWrite;
    logic [ADDR_WIDTH-1:0]   Address;
    logic [DATA_WIDTH-1:0]   WriteData;
    logic [DATA_WIDTH/8-1:0] ByteEn;
    logic [DATA_WIDTH-1:0]   ReadData;
    logic                    MemReady;
    logic                    MemBusy;
    logic                    MemErr;

    modport master (
        output MemRead, MemWrite, Address, WriteData, ByteEn,
        input  ReadData, MemReady, MemBusy, MemErr
    );

    modport slave (
        input  MemRead, MemWrite, Address, WriteData, ByteEn,
        output ReadData, MemReady, MemBusy, MemErr
    );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x DATA_WIDTH storage with byte-lane synchronous write and a
// combinational read of the same word index.
module dmem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int IDX_W      = $clog2(DEPTH),
    parameter int BYTES      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [BYTES-1:0]      be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_memory_multicycle.sv
// Multi-cycle data memory: accepts one request, completes it ND cycles later
// with a one-cycle MemReady pulse, flagging misaligned/out-of-range addresses.
module data_memory_multicycle
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ND         = DEF_ND
) (
    input  logic                     clk,
    input  logic                     rst,
    data_memory_multicycle_if.slave  bus
);
    localparam int BYTES = lanes_of(DATA_WIDTH);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(ND);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BYTES-1:0]      be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  enter_done;
    logic                  we;
    logic                  addr_err;

    // DEPTH is a power of two, so "Address >= DEPTH*4" is any bit set above the index.
    assign addr_err = (bus.Address[1:0] != 2'b00) ||
                      ((bus.Address >> (IDX_W + 2)) != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        err_d      = err_q;
        idx_d      = idx_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        enter_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.MemRead || bus.MemWrite) begin
                    wr_d    = bus.MemWrite;
                    err_d   = addr_err;
                    idx_d   = bus.Address[IDX_W+1:2];
                    be_d    = bus.ByteEn;
                    wdata_d = bus.WriteData;
                    cnt_d   = CNT_W'(ND - 1);
                    if (ND == 1) begin
                        state_d    = ST_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The _d request fields equal the inputs on an ND=1 accept and the latches otherwise.
    assign we = enter_done && wr_d && !err_d && !rst;

    always_comb begin
        rdata_d = rdata_q;
        if (enter_done) begin
            if (err_d) begin
                rdata_d = '0;
            end else if (!wr_d) begin
                rdata_d = rd_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .BYTES      (BYTES)
    ) u_array (
        .clk     (clk),
        .we_i    (we),
        .idx_i   (idx_d),
        .be_i    (be_d),
        .wdata_i (wdata_d),
        .rdata_o (rd_word)
    );

    assign bus.ReadData = rdata_q;
    assign bus.MemReady = (state_q == ST_DONE);
    assign bus.MemBusy  = (state_q != ST_IDLE);
    assign bus.MemErr   = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_data_memory_multicycle.sv
// Directed bench for data_memory_multicycle with ND=3, 32-bit words, 256 words.
module tb_data_memory_multicycle;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    data_memory_multicycle_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    data_memory_multicycle #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (256),
        .ND         (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.Address   = '0;
        bus.WriteData = '0;
        bus.ByteEn    = '0;
    endtask

    // One request; lat counts edges after the accept edge until MemReady (-1 on timeout).
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output int lat, output logic [31:0] rdata,
                          output logic err, output logic busy_all, output logic busy_after);
        bus.MemWrite  = wr;
        bus.MemRead   = !wr;
        bus.Address   = addr;
        bus.WriteData = wdata;
        bus.ByteEn    = be;
        tick();
        idle_inputs();
        lat = -1; rdata = '0; err = 1'b0; busy_all = 1'b1;
        for (int n = 0; n < 20; n++) begin
            busy_all &= bus.MemBusy;
            if (bus.MemReady) begin
                lat = n; rdata = bus.ReadData; err = bus.MemErr;
                break;
            end
            tick();
        end
        tick();
        busy_after = bus.MemBusy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        total++; if (bus.ReadData !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h expected 0", bus.ReadData); end
        total++; if (bus.MemReady !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b expected 0", bus.MemReady); end
        total++; if (bus.MemBusy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", bus.MemBusy); end
        total++; if (bus.MemErr !== 1'b0) begin bad++; $display("FAIL rst_err: got %b expected 0", bus.MemErr); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int lat; logic [31:0] rd; logic err, ba, bz;
        do_req(1'b1, 32'd64, 32'd45, 4'hF, lat, rd, err, ba, bz);
        total++; if (lat !== 3) begin bad++; $display("FAIL w64_lat: got %0d expected 3", lat); end
        total++; if (ba !== 1'b1) begin bad++; $display("FAIL w64_busy: got %b expected 1", ba); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL w64_err: got %b expected 0", err); end
        total++; if (bz !== 1'b0) begin bad++; $display("FAIL w64_busy_after: got %b expected 0", bz); end
        do_req(1'b1, 32'd128, 32'd100, 4'hF, lat, rd, err, ba, bz);
        total++; if (lat !== 3) begin bad++; $display("FAIL w128_lat: got %0d expected 3", lat); end
        total++; if (ba !== 1'b1) begin bad++; $display("FAIL w128_busy: got %b expected 1", ba); end
    endtask

    task automatic test_read();
        int lat; logic [31:0] rd; logic err, ba, bz;
        do_req(1'b0, 32'd64, 32'h0, 4'h0, lat, rd, err, ba, bz);
        total++; if (lat !== 3) begin bad++; $display("FAIL r64_lat: got %0d expected 3", lat); end
        total++; if (rd !== 32'd45) begin bad++; $display("FAIL r64_data: got %h expected %h", rd, 32'd45); end
        do_req(1'b0, 32'd128, 32'h0, 4'h0, lat, rd, err, ba, bz);
        total++; if (rd !== 32'd100) begin bad++; $display("FAIL r128_data: got %h expected %h", rd, 32'd100); end
        tick(); tick();
        total++; if (bus.ReadData !== 32'd100) begin bad++; $display("FAIL r128_hold: got %h expected %h", bus.ReadData, 32'd100); end
        // A completing write must leave the last read value in place.
        do_req(1'b1, 32'd192, 32'd7, 4'hF, lat, rd, err, ba, bz);
        total++; if (rd !== 32'd100) begin bad++; $display("FAIL wr_keeps_rdata: got %h expected %h", rd, 32'd100); end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] rd; logic err, ba, bz;
        do_req(1'b1, 32'd64, 32'h11223344, 4'hF, lat, rd, err, ba, bz);
        // Lanes 0 and 2 only: bytes DD and BB land, bytes 1 and 3 keep 33 and 11.
        do_req(1'b1, 32'd64, 32'hAABBCCDD, 4'b0101, lat, rd, err, ba, bz);
        do_req(1'b0, 32'd64, 32'h0, 4'h0, lat, rd, err, ba, bz);
        total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL be0101: got %h expected 11bb33dd", rd); end
        do_req(1'b1, 32'd64, 32'hAABBCCDD, 4'b0111, lat, rd, err, ba, bz);
        do_req(1'b0, 32'd64, 32'h0, 4'h0, lat, rd, err, ba, bz);
        total++; if (rd !== 32'h11BBCCDD) begin bad++; $display("FAIL be0111: got %h expected 11bbccdd", rd); end
        do_req(1'b1, 32'd64, 32'hFFFFFFFF, 4'b0000, lat, rd, err, ba, bz);
        total++; if (lat !== 3) begin bad++; $display("FAIL be0000_lat: got %0d expected 3", lat); end
        do_req(1'b0, 32'd64, 32'h0, 4'h0, lat, rd, err, ba, bz);
        total++; if (rd !== 32'h11BBCCDD) begin bad++; $display("FAIL be0000_data: got %h expected 11bbccdd", rd); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] ready_mask, idle_mask;
        logic [31:0] rd;
        ready_mask = '0; idle_mask = '0; rd = '0;
        bus.MemRead = 1'b1;
        bus.Address = 32'd128;
        // Accept at edge 1, DONE at 4, IDLE at 5, re-accept at 6, DONE at 9, IDLE at 10.
        for (int n = 0; n < 10; n++) begin
            tick();
            ready_mask[n] = bus.MemReady;
            idle_mask[n]  = !bus.MemBusy;
            if (bus.MemReady) rd = bus.ReadData;
        end
        idle_inputs();
        tick();
        total++; if (ready_mask !== 10'h108) begin bad++; $display("FAIL b2b_ready: got %h expected 108", ready_mask); end
        total++; if (idle_mask !== 10'h210) begin bad++; $display("FAIL b2b_idle: got %h expected 210", idle_mask); end
        total++; if (rd !== 32'd100) begin bad++; $display("FAIL b2b_data: got %h expected %h", rd, 32'd100); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic err, ba, bz;
        do_req(1'b1, 32'd0, 32'h5A5A5A5A, 4'hF, lat, rd, err, ba, bz);
        do_req(1'b0, 32'd128, 32'h0, 4'h0, lat, rd, err, ba, bz);
        do_req(1'b1, 32'd66, 32'hDEADBEEF, 4'hF, lat, rd, err, ba, bz);
        total++; if (lat !== 3) begin bad++; $display("FAIL mis_lat: got %0d expected 3", lat); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL mis_err: got %b expected 1", err); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mis_rdata: got %h expected 0", rd); end
        do_req(1'b1, 32'd1024, 32'hDEADBEEF, 4'hF, lat, rd, err, ba, bz);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_err: got %b expected 1", err); end
        do_req(1'b0, 32'd64, 32'h0, 4'h0, lat, rd, err, ba, bz);
        total++; if (rd !== 32'h11BBCCDD) begin bad++; $display("FAIL mis_nowrite: got %h expected 11bbccdd", rd); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ok_err: got %b expected 0", err); end
        // 1024 aliases index 0 if the error gate is missing.
        do_req(1'b0, 32'd0, 32'h0, 4'h0, lat, rd, err, ba, bz);
        total++; if (rd !== 32'h5A5A5A5A) begin bad++; $display("FAIL oor_nowrite: got %h expected 5a5a5a5a", rd); end
        do_req(1'b1, 32'd1020, 32'h0BADF00D, 4'hF, lat, rd, err, ba, bz);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL last_err: got %b expected 0", err); end
        do_req(1'b0, 32'd1020, 32'h0, 4'h0, lat, rd, err, ba, bz);
        total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL last_data: got %h expected 0badf00d", rd); end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic err, ba, bz;
        logic any_ready;
        bus.MemWrite = 1'b1; bus.Address = 32'd64; bus.WriteData = 32'hDEADBEEF; bus.ByteEn = 4'hF;
        tick();
        idle_inputs();
        total++; if (bus.MemBusy !== 1'b1) begin bad++; $display("FAIL abort_busy: got %b expected 1", bus.MemBusy); end
        tick();
        rst = 1'b1;
        tick();
        total++; if (bus.MemReady !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b expected 0", bus.MemReady); end
        total++; if (bus.MemBusy !== 1'b0) begin bad++; $display("FAIL abort_idle: got %b expected 0", bus.MemBusy); end
        total++; if (bus.ReadData !== 32'h0) begin bad++; $display("FAIL abort_rdata: got %h expected 0", bus.ReadData); end
        tick();
        rst = 1'b0;
        any_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            any_ready |= bus.MemReady;
        end
        total++; if (any_ready !== 1'b0) begin bad++; $display("FAIL abort_noready: got %b expected 0", any_ready); end
        do_req(1'b0, 32'd64, 32'h0, 4'h0, lat, rd, err, ba, bz);
        total++; if (lat !== 3) begin bad++; $display("FAIL abort_rd_lat: got %0d expected 3", lat); end
        total++; if (rd !== 32'h11BBCCDD) begin bad++; $display("FAIL abort_nowrite: got %h expected 11bbccdd", rd); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_byte_lanes();
        test_back_to_back();
        test_errors();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
